ifetch_pc_gen: RTL



---
 rtl/ifetch_pc_gen.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/ifetch_pc_gen.sv
// ifetch_pc_gen: PC generation and instruction-fetch stage feeding the IF/ID register.
//
// Holds the fetch PC and issues one outstanding request at a time to the
// instruction SRAM. Every cycle it presents pc/inst/fetch-exception info to IF/ID.
// When no instruction is ready it inserts a bubble (all zero). It applies jump
// redirects (with a delay slot) and exception/interrupt redirects. An exception
// redirect cancels any fetch that is still in flight.
//
// Optional build macro: FETCH_PERF_CNT_EN adds the perf_fetch_cnt and
// perf_wait_cnt outputs.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   stall                downstream stall; outputs hold while set
//   jmp, jmp_target      taken branch/jump from ID
//   int_flush, ex_vector exception/interrupt redirect from CP0
//   inst_req, inst_addr  SRAM request
//   inst_addr_ok         request accepted this cycle
//   inst_data_ok         read data valid this cycle
//   inst_rdata           read data
//   pc, inst             PC and instruction to IF/ID (inst = 0 is a bubble)
//   cp0_ex, cp0_excode, cp0_badvaddr  fetch exception info
//   perf_fetch_cnt, perf_wait_cnt     (FETCH_PERF_CNT_EN only)
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_REQ  | requesting fetch_pc, or raising AdEL when fetch_pc is misaligned
// S_WAIT | request accepted; waiting for data (dropped if cancel is set)
// S_HOLD | data arrived during a stall and is parked in the pending buffer
// S_HALT | misaligned fetch reported; only int_flush leaves this state

module ifetch_pc_gen #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [4:0]  ADEL_CODE = 5'h04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        int_flush,
    input  logic [31:0] ex_vector,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        cp0_ex,
    output logic [4:0]  cp0_excode,
    output logic [31:0] cp0_badvaddr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic        cancel;
    logic        pend_valid;
    logic [31:0] pend_pc;
    logic [31:0] pend_inst;

    logic        misaligned;
    logic        deliver;
    logic        advance;
    logic [31:0] dl_pc;
    logic [31:0] dl_inst;
    logic        dl_ex;
    logic [31:0] adv_pc;

    assign misaligned = |fetch_pc[1:0];
    // Gated by reset so that no request appears while reset is held.
    assign inst_req   = !reset && (state == S_REQ) && !misaligned;
    assign inst_addr  = fetch_pc;
    // The address after the current fetch. A jump in the same cycle as the
    // advance is for the instruction that is leaving now, which is the delay slot.
    assign adv_pc     = jmp ? jmp_target : next_pc;

    always_comb begin
        deliver = 1'b0;
        advance = 1'b0;
        dl_pc   = fetch_pc;
        dl_inst = 32'd0;
        dl_ex   = 1'b0;
        if (!stall) begin
            case (state)
                S_REQ: begin
                    if (misaligned) begin
                        deliver = 1'b1;
                        dl_ex   = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok && !cancel) begin
                        deliver = 1'b1;
                        advance = 1'b1;
                        dl_inst = inst_rdata;
                    end
                end
                S_HOLD: begin
                    if (pend_valid) begin
                        deliver = 1'b1;
                        advance = 1'b1;
                        dl_pc   = pend_pc;
                        dl_inst = pend_inst;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_REQ;
            fetch_pc     <= RESET_PC;
            next_pc      <= RESET_PC + 32'd4;
            cancel       <= 1'b0;
            pend_valid   <= 1'b0;
            pend_pc      <= 32'd0;
            pend_inst    <= 32'd0;
            pc           <= 32'd0;
            inst         <= 32'd0;
            cp0_ex       <= 1'b0;
            cp0_excode   <= 5'd0;
            cp0_badvaddr <= 32'd0;
        end else begin
            // A flush forces a bubble even while the stage is stalled.
            if (int_flush || !stall) begin
                if (!int_flush && deliver) begin
                    pc           <= dl_pc;
                    inst         <= dl_inst;
                    cp0_ex       <= dl_ex;
                    cp0_excode   <= dl_ex ? ADEL_CODE : 5'd0;
                    cp0_badvaddr <= dl_ex ? dl_pc : 32'd0;
                end else begin
                    pc           <= 32'd0;
                    inst         <= 32'd0;
                    cp0_ex       <= 1'b0;
                    cp0_excode   <= 5'd0;
                    cp0_badvaddr <= 32'd0;
                end
            end

            if (int_flush) begin
                fetch_pc   <= ex_vector;
                next_pc    <= ex_vector + 32'd4;
                pend_valid <= 1'b0;
                case (state)
                    S_REQ: begin
                        // An accepted request still returns data; drop it on arrival.
                        if (inst_req && inst_addr_ok) begin
                            cancel <= 1'b1;
                            state  <= S_WAIT;
                        end else begin
                            state  <= S_REQ;
                        end
                    end
                    S_WAIT: begin
                        if (inst_data_ok) begin
                            cancel <= 1'b0;
                            state  <= S_REQ;
                        end else begin
                            cancel <= 1'b1;
                            state  <= S_WAIT;
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end else begin
                case (state)
                    S_REQ: begin
                        if (misaligned) begin
                            if (!stall) state <= S_HALT;
                        end else if (inst_addr_ok) begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (inst_data_ok) begin
                            if (cancel) begin
                                cancel <= 1'b0;
                                state  <= S_REQ;
                            end else if (!stall) begin
                                state <= S_REQ;
                            end else begin
                                pend_valid <= 1'b1;
                                pend_pc    <= fetch_pc;
                                pend_inst  <= inst_rdata;
                                state      <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            pend_valid <= 1'b0;
                            state      <= S_REQ;
                        end
                    end
                    default: ;
                endcase

                if (advance) begin
                    fetch_pc <= adv_pc;
                    next_pc  <= adv_pc + 32'd4;
                end else if (jmp) begin
                    next_pc <= jmp_target;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= 32'd0;
            perf_wait_cnt  <= 32'd0;
        end else begin
            // Count only real instructions: an AdEL report and a flushed delivery are excluded.
            if (deliver && advance && !int_flush)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state == S_WAIT || state == S_HOLD)
                perf_wait_cnt <= perf_wait_cnt + 32'd1;
        end
    end
`endif

endmodule
